mioc_gate_pattern_seq: RTL and testbench

//  On-chip stimulus/capture sequencer for MIOC 4-input MOS gate test structures
//  (e.g. the AND2-NOR cell). It sits directly upstream of the gate under test.
//  It drives in1..in4 through NUM_PATTERNS input codes and lets each settle.
//  It samples the gate output z through a 2-FF synchronizer and compares it

---
 rtl/mioc_gate_pattern_seq.sv | 127 ++++++++++++
 tb/tb_mioc_gate_pattern_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mioc_gate_pattern_seq.sv
// Stimulus/capture sequencer for 4-input MIOC gate test structures: steps the
// gate inputs through every code, samples the synchronized z and scores it.
module mioc_gate_pattern_seq #(
  parameter int          NUM_PATTERNS  = 16,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = 16'h0111
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_gate_z,
  output logic [3:0]  o_gate_in,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [4:0]  o_fail_cnt,
  output logic [15:0] o_result_vec
);

  // state    | meaning
  // S_IDLE   | waiting for start; gate_in holds last pattern
  // S_DRIVE  | apply current code to the gate
  // S_SETTLE | hold code for SETTLE_CYCLES clocks
  // S_SAMPLE | capture synchronized z and score it
  // S_DONE   | one-cycle done pulse, pass valid
  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    PAT_LAST = 4'(NUM_PATTERNS - 1);

  state_t        r_state;
  logic [3:0]    r_pat;
  logic [CW-1:0] r_cnt;
  logic          r_z1;
  logic          r_z2;
  logic [3:0]    r_gate_in;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [4:0]    r_fail_cnt;
  logic [15:0]   r_result_vec;

  logic          w_mismatch;
  logic [4:0]    w_fail_next;
  logic          w_last;

  assign w_mismatch  = (r_z2 != EXPECTED[r_pat]);
  assign w_fail_next = r_fail_cnt + {4'b0000, w_mismatch};
  assign w_last      = (r_pat == PAT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pat        <= '0;
      r_cnt        <= '0;
      r_z1         <= 1'b0;
      r_z2         <= 1'b0;
      r_gate_in    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_cnt   <= '0;
      r_result_vec <= '0;
    end else begin
      r_z1   <= i_gate_z;
      r_z2   <= r_z1;
      r_done <= 1'b0;
      if (i_abort && (r_state == S_DRIVE || r_state == S_SETTLE || r_state == S_SAMPLE)) begin
        // abort leaves the partial score visible for readout
        r_state   <= S_IDLE;
        r_gate_in <= '0;
        r_busy    <= 1'b0;
        r_pass    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state      <= S_DRIVE;
              r_pat        <= '0;
              r_gate_in    <= '0;
              r_fail_cnt   <= '0;
              r_result_vec <= '0;
              r_pass       <= 1'b0;
              r_busy       <= 1'b1;
            end
          end
          S_DRIVE: begin
            r_gate_in <= r_pat;
            r_cnt     <= '0;
            r_state   <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_cnt == CNT_LAST) r_state <= S_SAMPLE;
            else                   r_cnt   <= r_cnt + CW'(1);
          end
          S_SAMPLE: begin
            r_result_vec[r_pat] <= r_z2;
            r_fail_cnt          <= w_fail_next;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_fail_next == 5'd0);
            end else begin
              r_pat   <= r_pat + 4'd1;
              r_state <= S_DRIVE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_gate_in    = r_gate_in;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_fail_cnt   = r_fail_cnt;
  assign o_result_vec = r_result_vec;

endmodule

// File: tb/tb_mioc_gate_pattern_seq.sv
// Directed bench for mioc_gate_pattern_seq: expected run results are queued at
// start time and scored by a monitor on each done pulse.
module tb_mioc_gate_pattern_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        gate_z;
  logic [3:0]  gate_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  fail_cnt;
  logic [15:0] result_vec;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int mode = 0;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  fc;
    logic        ps;
    int          cyc;
  } exp_t;
  exp_t q[$];

  mioc_gate_pattern_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_gate_z    (gate_z),
    .o_gate_in   (gate_in),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_fail_cnt  (fail_cnt),
    .o_result_vec(result_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // gate under test models: 0 = AND2-NOR, 1 = stuck-at-1, 2 = NAND2
  always_comb begin
    gate_z = 1'b0;
    case (mode)
      1:       gate_z = 1'b1;
      2:       gate_z = ~(gate_in[3] & gate_in[2]);
      default: gate_z = ~((gate_in[3] & gate_in[2]) | gate_in[1] | gate_in[0]);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      chk("done_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("result_vec", 32'(result_vec), 32'(e.res));
        chk("fail_cnt", 32'(fail_cnt), 32'(e.fc));
        chk("pass", 32'(pass), 32'(e.ps));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // returns k = cycle number of the accepting edge
  task automatic start_run(input logic push, input logic [15:0] res, input logic [4:0] fc,
                           input logic ps, input logic with_abort, output int k);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    abort = 1'b0;
    if (push) begin
      e.res = res; e.fc = fc; e.ps = ps; e.cyc = k + 96;
      q.push_back(e);
    end
  endtask

  task automatic wait_done(input int n0);
    int t = 0;
    while (done_cnt <= n0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("done_seen", 32'(done_cnt > n0), 32'd1);
  endtask

  task automatic wait_cyc(input int c);
    int t = 0;
    while (cyc < c && t < 300) begin
      @(posedge clk);
      t++;
    end
  endtask

  initial begin
    int k, n0, bad;
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gate_in", 32'(gate_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_result_vec", 32'(result_vec), 32'd0);
    rst_n = 1'b1;

    // 1: correct gate, gate_in stepping and hold times
    mode = 0;
    n0 = done_cnt;
    start_run(1'b1, 16'h0111, 5'd0, 1'b1, 1'b0, k);
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int p = 0; p < 16; p++) begin
      bad = 0;
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        if (gate_in !== 4'(p)) bad++;
      end
      chk($sformatf("gate_in_hold_p%0d", p), 32'(bad), 32'd0);
    end
    wait_done(n0);
    repeat (2) @(negedge clk);
    chk("gate_in_holds_last", 32'(gate_in), 32'hF);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2: stuck-at-1; start with abort in IDLE must still start
    mode = 1;
    n0 = done_cnt;
    start_run(1'b1, 16'hFFFF, 5'd13, 1'b0, 1'b1, k);
    wait_done(n0);

    // 3: NAND2 disagrees with AND2-NOR on codes 1-3, 5-7, 9-11
    mode = 2;
    n0 = done_cnt;
    start_run(1'b1, 16'h0FFF, 5'd9, 1'b0, 1'b0, k);
    wait_done(n0);

    // 4: start held high throughout; retry accepted only once back in IDLE
    mode = 0;
    n0 = done_cnt;
    start_run(1'b1, 16'h0111, 5'd0, 1'b1, 1'b0, k);
    start = 1'b1;
    wait_done(n0);
    wait_cyc(k + 98);
    #1;
    start = 1'b0;
    begin
      exp_t e;
      e.res = 16'h0111; e.fc = 5'd0; e.ps = 1'b1; e.cyc = k + 98 + 96;
      q.push_back(e);
    end
    @(negedge clk);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_done(n0 + 1);
    chk("restart_done_count", 32'(done_cnt - n0), 32'd2);

    // 5: abort in SAMPLE of code 5
    n0 = done_cnt;
    start_run(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, k);
    wait_cyc(k + 35);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_gate_in", 32'(gate_in), 32'd0);
    chk("abort_result_vec", 32'(result_vec), 32'h0011);
    chk("abort_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    repeat (110) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - n0), 32'd0);
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // 6: reset during SETTLE of code 9, then a clean run
    start_run(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, k);
    wait_cyc(k + 56);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_gate_in", 32'(gate_in), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pass", 32'(pass), 32'd0);
    chk("midrst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("midrst_result_vec", 32'(result_vec), 32'd0);
    n0 = done_cnt;
    start_run(1'b1, 16'h0111, 5'd0, 1'b1, 1'b0, k);
    wait_done(n0);

    repeat (3) @(negedge clk);
    chk("pending_expectations", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
